// File: rtl/sub_pkg.sv
// Shared definitions for the nibble-serial 16-bit subtractor.
package sub_pkg;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = 4;
  localparam int IDX_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_slice_4bit.sv
// 4-bit carry-lookahead adder slice. The subtractor feeds the inverted
// subtrahend nibble on y, so a carry out of 1 means "no borrow".
module sub_slice_4bit
  import sub_pkg::*;
(
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             c_in,
  output logic [SLICE-1:0] s,
  output logic             c_out
);

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic             c1;
  logic             c2;
  logic             c3;

  assign g = x & y;
  assign p = x ^ y;

  // Lookahead carries, each expanded directly from generate/propagate terms.
  assign c1 = g[0] | (p[0] & c_in);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & c_in);
  assign c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c_in);

  assign s = p ^ {c3, c2, c1, c_in};

endmodule

// File: rtl/serial_subtractor_16bit.sv
// Nibble-serial 16-bit subtractor: D = A - B - b_in, one 4-bit lookahead
// slice reused over four clocks, LSB nibble first, valid/ready handshakes
// on both sides.
// Optional macro SUB_FLAGS_EN adds registered ovf/zero flag outputs.
module serial_subtractor_16bit
  import sub_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             b_in,
  output logic [WIDTH-1:0] D,
  output logic             b_out,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SUB_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             out_valid_q, out_valid_d;
`ifdef SUB_FLAGS_EN
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
`endif

  logic [SLICE-1:0] nib_x;
  logic [SLICE-1:0] nib_y;
  logic [SLICE-1:0] nib_s;
  logic             nib_c;
  logic [WIDTH-1:0] full_d;

  // Select the current nibble of the latched operands; B is inverted here.
  always_comb begin
    nib_x = a_q[{idx_q, 2'b00} +: SLICE];
    nib_y = ~b_q[{idx_q, 2'b00} +: SLICE];
  end

  sub_slice_4bit u_slice (
    .x     (nib_x),
    .y     (nib_y),
    .c_in  (carry_q),
    .s     (nib_s),
    .c_out (nib_c)
  );

  // Complete difference as it will look once the top nibble is written.
  assign full_d = {nib_s, d_q[WIDTH-SLICE-1:0]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)          state_d = CALC;
      CALC:    if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (out_ready)         state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready = (state_q == IDLE);
  end

  // Datapath next values: operand capture, nibble step, result hold/release.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    d_d         = d_q;
    bout_d      = bout_q;
    out_valid_d = out_valid_q;
`ifdef SUB_FLAGS_EN
    ovf_d       = ovf_q;
    zero_d      = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          carry_d = ~b_in;
          idx_d   = '0;
        end
      end
      CALC: begin
        d_d[{idx_q, 2'b00} +: SLICE] = nib_s;
        carry_d = nib_c;
        idx_d   = idx_q + 2'd1;
        if (idx_q == LAST_IDX) begin
          bout_d      = ~nib_c;
          out_valid_d = 1'b1;
`ifdef SUB_FLAGS_EN
          ovf_d  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (full_d[WIDTH-1] ^ a_q[WIDTH-1]);
          zero_d = (full_d == '0);
`endif
        end
      end
      DONE: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset also abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      d_q         <= '0;
      bout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SUB_FLAGS_EN
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
`endif
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      d_q         <= d_d;
      bout_q      <= bout_d;
      out_valid_q <= out_valid_d;
`ifdef SUB_FLAGS_EN
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
`endif
    end
  end

  assign D         = d_q;
  assign b_out     = bout_q;
  assign out_valid = out_valid_q;
`ifdef SUB_FLAGS_EN
  assign ovf       = ovf_q;
  assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// Directed testbench for serial_subtractor_16bit (flag outputs checked
// only when SUB_FLAGS_EN is defined).
module tb_serial_subtractor_16bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A_i;
  logic [15:0] B_i;
  logic        b_in_i;
  logic [15:0] D;
  logic        b_out;
  logic        out_valid;
  logic        out_ready;
`ifdef SUB_FLAGS_EN
  logic        ovf;
  logic        zero;
`endif

  int checks = 0;
  int passed = 0;

  serial_subtractor_16bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A_i),
    .B         (B_i),
    .b_in      (b_in_i),
    .D         (D),
    .b_out     (b_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SUB_FLAGS_EN
    ,
    .ovf       (ovf),
    .zero      (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bi;
    logic [15:0] d;
    logic        bo;
    logic        ovf;
    logic        zero;
  } vec_t;

  // Offer one operand set, scramble the inputs right after the accept edge,
  // then wait (bounded) for out_valid. lat = clocks from accept to out_valid.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic bi, output int lat);
    @(negedge clk);
    A_i = a; B_i = b; b_in_i = bi; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A_i = ~a; B_i = 16'h5A5A; b_in_i = ~bi;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
  endtask

  // Single-cycle out_ready pulse to consume the held result.
  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A_i = 16'hFFFF; B_i = 16'h0001; b_in_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (D !== 16'h0000) $display("FAIL reset_D got %h want 0000", D); else passed++;
    checks++; if (b_out !== 1'b0) $display("FAIL reset_b_out got %b want 0", b_out); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
`ifdef SUB_FLAGS_EN
    checks++; if ({ovf, zero} !== 2'b00) $display("FAIL reset_flags got %b want 00", {ovf, zero}); else passed++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_vectors();
    vec_t vt [7];
    int   lat;
    vt[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vt[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vt[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vt[3] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vt[4] = '{16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vt[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vt[6] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].bi, lat);
      checks++; if (lat !== 4) $display("FAIL vec%0d_latency got %0d want 4", i, lat); else passed++;
      checks++; if (D !== vt[i].d) $display("FAIL vec%0d_D got %h want %h", i, D, vt[i].d); else passed++;
      checks++; if (b_out !== vt[i].bo) $display("FAIL vec%0d_b_out got %b want %b", i, b_out, vt[i].bo); else passed++;
`ifdef SUB_FLAGS_EN
      checks++; if (ovf !== vt[i].ovf) $display("FAIL vec%0d_ovf got %b want %b", i, ovf, vt[i].ovf); else passed++;
      checks++; if (zero !== vt[i].zero) $display("FAIL vec%0d_zero got %b want %b", i, zero, vt[i].zero); else passed++;
`endif
      release_out();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL vec%0d_release got out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(16'h1234, 16'h0234, 1'b0, lat);
    checks++; if (lat !== 4) $display("FAIL bp_first_latency got %0d want 4", lat); else passed++;
    @(negedge clk);
    in_valid = 1'b1; A_i = 16'h00FF; B_i = 16'h000F; b_in_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (D !== 16'h1000 || out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL bp_hold%0d got D=%h ov=%b ir=%b want 1000/1/0", c, D, out_valid, in_ready);
      else passed++;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_idle got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    else passed++;
    @(posedge clk);
    #1;
    in_valid = 1'b0; A_i = 16'hDEAD; B_i = 16'hBEEF;
    checks++; if (in_ready !== 1'b0) $display("FAIL bp_accept got in_ready=%b want 0", in_ready); else passed++;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
    checks++; if (lat !== 4) $display("FAIL bp_second_latency got %0d want 4", lat); else passed++;
    checks++; if (D !== 16'h00F0) $display("FAIL bp_second_D got %h want 00F0", D); else passed++;
    checks++; if (b_out !== 1'b0) $display("FAIL bp_second_b_out got %b want 0", b_out); else passed++;
    release_out();
  endtask

  task automatic test_reset_mid_calc();
    int  lat;
    logic seen;
    @(negedge clk);
    A_i = 16'hFFFF; B_i = 16'h0000; b_in_i = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (D !== 16'h0000) $display("FAIL midrst_D got %h want 0000", D); else passed++;
    checks++; if (b_out !== 1'b0) $display("FAIL midrst_b_out got %b want 0", b_out); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready got %b want 1", in_ready); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) $display("FAIL midrst_no_emit got %b want 0", seen); else passed++;
    run_op(16'h4321, 16'h1111, 1'b1, lat);
    checks++; if (lat !== 4) $display("FAIL midrst_next_latency got %0d want 4", lat); else passed++;
    checks++; if (D !== 16'h320F) $display("FAIL midrst_next_D got %h want 320F", D); else passed++;
    checks++; if (b_out !== 1'b0) $display("FAIL midrst_next_b_out got %b want 0", b_out); else passed++;
    release_out();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid_calc();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
